// File: rtl/uart_alu_pkg.sv
// rtl/uart_alu_pkg.sv - shared widths, ALU opcodes and sequencer state encoding
package uart_alu_pkg;

    localparam int DEF_NB_DATA = 8;
    localparam int DEF_NB_OP   = 6;

    localparam logic [DEF_NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [DEF_NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [DEF_NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [DEF_NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [DEF_NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [DEF_NB_OP-1:0] OP_NOR = 6'b100111;
    localparam logic [DEF_NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [DEF_NB_OP-1:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

endpackage

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - UART-to-ALU frame sequencer; inter-byte timeout enabled by UART_ALU_TIMEOUT_EN
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_OP   = DEF_NB_OP
`ifdef UART_ALU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_err
);

    state_t state;
    logic   timeout_hit;

    function automatic logic op_valid(input logic [NB_OP-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_valid = 1'b1;
            default:                        op_valid = 1'b0;
        endcase
    endfunction

`ifdef UART_ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic             in_frame;

    assign in_frame    = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
    assign timeout_hit = in_frame && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Inter-byte idle counter: restarts on every byte and whenever a partial frame is not pending
    always_ff @(posedge clk) begin
        if (i_reset || i_rx_done || !in_frame) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign o_busy = (state == ST_EXEC) || (state == ST_SEND) || (state == ST_WAIT_TX);

    // Frame sequencer: collect A, B, opcode, run the ALU, hand the result to TX, await completion
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state      <= ST_WAIT_A;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_err      <= 1'b0;
            case (state)
                ST_WAIT_A: begin
                    if (i_rx_done) begin
                        o_alu_a <= i_rx_data;
                        state   <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (i_rx_done) begin
                        o_alu_b <= i_rx_data;
                        state   <= ST_WAIT_OP;
                    end else if (timeout_hit) begin
                        o_err <= 1'b1;
                        state <= ST_WAIT_A;
                    end
                end
                ST_WAIT_OP: begin
                    if (i_rx_done) begin
                        o_alu_op <= i_rx_data[NB_OP-1:0];
                        if (op_valid(i_rx_data[NB_OP-1:0])) begin
                            state <= ST_EXEC;
                        end else begin
                            o_err <= 1'b1;
                            state <= ST_WAIT_A;
                        end
                    end else if (timeout_hit) begin
                        o_err <= 1'b1;
                        state <= ST_WAIT_A;
                    end
                end
                ST_EXEC: begin
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    o_err      <= i_rx_done;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    o_err <= i_rx_done;
                    state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    o_err <= i_rx_done;
                    if (i_tx_done) begin
                        state <= ST_WAIT_A;
                    end
                end
                default: state <= ST_WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb/tb_uart_alu_ctrl.sv - directed self-checking bench for uart_alu_ctrl
module tb_uart_alu_ctrl;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_rx_done = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic [7:0] i_alu_result;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_err;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

`ifdef UART_ALU_TIMEOUT_EN
    uart_alu_ctrl #(.TIMEOUT_CYCLES(16)) dut (
`else
    uart_alu_ctrl dut (
`endif
        .clk(clk), .i_reset(i_reset), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .i_alu_result(i_alu_result), .i_tx_done(i_tx_done), .o_alu_a(o_alu_a),
        .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start), .o_busy(o_busy), .o_err(o_err)
    );

    // Reference ALU standing in for the real combinational ALU
    always_comb begin
        case (o_alu_op)
            6'b100000: i_alu_result = o_alu_a + o_alu_b;
            6'b100010: i_alu_result = o_alu_a - o_alu_b;
            6'b100100: i_alu_result = o_alu_a & o_alu_b;
            6'b100101: i_alu_result = o_alu_a | o_alu_b;
            6'b100110: i_alu_result = o_alu_a ^ o_alu_b;
            6'b100111: i_alu_result = ~(o_alu_a | o_alu_b);
            6'b000011: i_alu_result = $signed(o_alu_a) >>> o_alu_b;
            6'b000010: i_alu_result = o_alu_a >> o_alu_b;
            default:   i_alu_result = 8'h00;
        endcase
    end

    // Pulse counters, sampled with the pre-edge value
    always @(posedge clk) begin
        if (o_tx_start) start_cnt <= start_cnt + 1;
        if (o_err) err_cnt <= err_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        total++; if ({o_alu_a, o_alu_b, o_alu_op, o_tx_data} !== 30'h0) begin
            bad++; $display("FAIL reset_regs: got %h want 0", {o_alu_a, o_alu_b, o_alu_op, o_tx_data}); end
        total++; if ({o_tx_start, o_busy, o_err} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {o_tx_start, o_busy, o_err}); end
    endtask

    task automatic test_add();
        int s0;
        s0 = start_cnt;
        send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
        total++; if (o_alu_op !== 6'h20) begin bad++; $display("FAIL add_op: got %h want 20", o_alu_op); end
        total++; if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
            bad++; $display("FAIL add_exec: start=%b busy=%b want 0 1", o_tx_start, o_busy); end
        tick();
        total++; if (o_tx_start !== 1'b1) begin bad++; $display("FAIL add_start: got %b want 1", o_tx_start); end
        total++; if (o_tx_data !== 8'h08) begin bad++; $display("FAIL add_data: got %h want 08", o_tx_data); end
        tick();
        total++; if (o_tx_start !== 1'b0 || start_cnt !== s0 + 1) begin
            bad++; $display("FAIL add_once: start=%b pulses=%0d want 0 %0d", o_tx_start, start_cnt - s0, 1); end
        tick();
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL add_wait_tx: busy got %b want 1", o_busy); end
        pulse_tx_done();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL add_done: busy got %b want 0", o_busy); end
    endtask

    task automatic test_sub_then_next();
        send_byte(8'h03); send_byte(8'h05); send_byte(8'h22);
        tick();
        total++; if (o_tx_data !== 8'hFE) begin bad++; $display("FAIL sub_data: got %h want FE", o_tx_data); end
        tick();
        pulse_tx_done();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL sub_done: busy got %b want 0", o_busy); end
        send_byte(8'h0F); send_byte(8'hF3); send_byte(8'h27);
        tick();
        total++; if (o_tx_data !== 8'h00 || o_tx_start !== 1'b1) begin
            bad++; $display("FAIL nor_data: got %h start=%b want 00 1", o_tx_data, o_tx_start); end
        tick();
        pulse_tx_done();
        send_byte(8'h81); send_byte(8'h02); send_byte(8'h03);
        tick();
        total++; if (o_tx_data !== 8'hE0) begin bad++; $display("FAIL sra_data: got %h want E0", o_tx_data); end
        tick();
        pulse_tx_done();
    endtask

    task automatic test_invalid_op();
        int s0;
        s0 = start_cnt;
        send_byte(8'h10); send_byte(8'h01); send_byte(8'h3F);
        total++; if (o_err !== 1'b1 || o_busy !== 1'b0) begin
            bad++; $display("FAIL inv_err: err=%b busy=%b want 1 0", o_err, o_busy); end
        total++; if (o_alu_op !== 6'h3F) begin bad++; $display("FAIL inv_op: got %h want 3F", o_alu_op); end
        tick(); tick(); tick();
        total++; if (o_err !== 1'b0 || start_cnt !== s0) begin
            bad++; $display("FAIL inv_no_tx: err=%b pulses=%0d want 0 0", o_err, start_cnt - s0); end
    endtask

    task automatic test_overrun();
        send_byte(8'h0C); send_byte(8'h0A); send_byte(8'h26);
        tick(); tick();
        send_byte(8'hAA);
        total++; if (o_err !== 1'b1 || o_alu_a !== 8'h0C || o_busy !== 1'b1) begin
            bad++; $display("FAIL ovr_wait_tx: err=%b a=%h busy=%b want 1 0c 1", o_err, o_alu_a, o_busy); end
        tick();
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL ovr_err_pulse: got %b want 0", o_err); end
        pulse_tx_done();
        total++; if (o_busy !== 1'b0 || o_tx_data !== 8'h06) begin
            bad++; $display("FAIL ovr_tx_done: busy=%b data=%h want 0 06", o_busy, o_tx_data); end
    endtask

    task automatic test_back_to_back();
        send_byte(8'hF0); send_byte(8'h04); send_byte(8'h02);
        send_byte(8'h77);
        total++; if (o_err !== 1'b1 || o_tx_start !== 1'b1 || o_tx_data !== 8'h0F) begin
            bad++; $display("FAIL exec_drop: err=%b start=%b data=%h want 1 1 0f", o_err, o_tx_start, o_tx_data); end
        total++; if (o_alu_a !== 8'hF0) begin bad++; $display("FAIL exec_keep_a: got %h want f0", o_alu_a); end
        tick();
        i_rx_data = 8'h55; i_rx_done = 1'b1; i_tx_done = 1'b1;
        tick();
        i_rx_done = 1'b0; i_tx_done = 1'b0;
        total++; if (o_err !== 1'b1 || o_busy !== 1'b0 || o_alu_a !== 8'hF0) begin
            bad++; $display("FAIL simul_rx_tx: err=%b busy=%b a=%h want 1 0 f0", o_err, o_busy, o_alu_a); end
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h11); send_byte(8'h22);
        i_reset = 1'b1; i_rx_data = 8'h99; i_rx_done = 1'b1;
        tick();
        i_reset = 1'b0; i_rx_done = 1'b0;
        total++; if ({o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_err, o_busy} !== 33'h0) begin
            bad++; $display("FAIL rst_mid: got a=%h b=%h op=%h d=%h want all 0", o_alu_a, o_alu_b, o_alu_op, o_tx_data); end
        send_byte(8'h04); send_byte(8'h05); send_byte(8'h25);
        tick();
        total++; if (o_alu_a !== 8'h04 || o_alu_b !== 8'h05 || o_tx_data !== 8'h05) begin
            bad++; $display("FAIL rst_fresh: a=%h b=%h d=%h want 04 05 05", o_alu_a, o_alu_b, o_tx_data); end
        tick();
        pulse_tx_done();
    endtask

`ifdef UART_ALU_TIMEOUT_EN
    task automatic test_timeout();
        send_byte(8'h01);
        repeat (15) tick();
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL tmo_early: err got %b want 0", o_err); end
        tick();
        total++; if (o_err !== 1'b1 || o_busy !== 1'b0) begin
            bad++; $display("FAIL tmo_fire: err=%b busy=%b want 1 0", o_err, o_busy); end
        send_byte(8'h06); send_byte(8'h07); send_byte(8'h20);
        total++; if (o_busy !== 1'b1 || o_alu_a !== 8'h06) begin
            bad++; $display("FAIL tmo_fresh: busy=%b a=%h want 1 06", o_busy, o_alu_a); end
        tick();
        total++; if (o_tx_data !== 8'h0D) begin bad++; $display("FAIL tmo_data: got %h want 0d", o_tx_data); end
        tick();
        pulse_tx_done();
    endtask
`else
    task automatic test_no_timeout();
        int e0;
        send_byte(8'h01);
        e0 = err_cnt;
        repeat (40) tick();
        total++; if (err_cnt !== e0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL idle_wait: errs=%0d busy=%b want 0 0", err_cnt - e0, o_busy); end
        send_byte(8'h02); send_byte(8'h20);
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL idle_resume: busy got %b want 1", o_busy); end
        tick();
        total++; if (o_tx_data !== 8'h03) begin bad++; $display("FAIL idle_data: got %h want 03", o_tx_data); end
        tick();
        pulse_tx_done();
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub_then_next();
        test_invalid_op();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_ALU_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
